activity_mode_ctrl: RTL

Front-end stage of the fitness tracker that turns raw, bouncy push-button inputs into the clean activity levels `Run`, `Walk` and `Cycle` consumed by `fitness_tracker`. It synchronizes and debounces four buttons and runs a mode state machine that guarantees at most one activity level is high. It also generates a one-second `tick` while an activity is active and keeps session bookkeeping: total active seconds and the number of mode changes.

---
 rtl/activity_mode_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/activity_mode_ctrl.sv
// activity_mode_ctrl: synchronizes and debounces the four activity buttons and runs the
// activity mode FSM (at most one of Run/Walk/Cycle high) with a 1 s tick and session counters.
module activity_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_walk,
    input  logic        btn_cycle,
    input  logic        btn_stop,
    output logic        Run,
    output logic        Walk,
    output logic        Cycle,
    output logic [1:0]  active_mode,
    output logic        tick,
    output logic [15:0] session_sec,
    output logic [7:0]  mode_changes
);

    localparam int NBTN      = 4;
    localparam int BTN_RUN   = 0;
    localparam int BTN_WALK  = 1;
    localparam int BTN_CYCLE = 2;
    localparam int BTN_STOP  = 3;
    localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int PRE_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WALK  = 2'd2,
        ST_CYCLE = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
        if (en && (v != 8'hFF)) begin
            return v + 8'd1;
        end else begin
            return v;
        end
    endfunction

    // Pressing the button of the mode already running toggles back to idle.
    function automatic state_e select_mode(input state_e cur, input state_e target);
        if (cur == target) begin
            return ST_IDLE;
        end else begin
            return target;
        end
    endfunction

    logic [NBTN-1:0]            btn_raw_s;
    logic [NBTN-1:0]            sync1_q;
    logic [NBTN-1:0]            sync2_q;
    logic [NBTN-1:0]            deb_q;
    logic [NBTN-1:0]            deb_d;
    logic [NBTN-1:0]            deb_prev_q;
    logic [NBTN-1:0]            press_s;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q;
    logic [NBTN-1:0][CNT_W-1:0] cnt_d;

    state_e                     state_q;
    state_e                     state_d;
    logic                       state_change_s;

    logic [PRE_W-1:0]           pre_q;
    logic [PRE_W-1:0]           pre_d;
    logic                       tick_q;
    logic                       tick_d;
    logic [15:0]                sec_q;
    logic [15:0]                sec_d;
    logic [7:0]                 chg_q;
    logic [7:0]                 chg_d;
    logic                       run_q;
    logic                       walk_q;
    logic                       cycle_q;

    assign btn_raw_s = {btn_stop, btn_cycle, btn_walk, btn_run};
    assign press_s   = deb_q & ~deb_prev_q;

    // Debounce next-state: a level change is accepted after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int b = 0; b < NBTN; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DEB_LAST) begin
                deb_d[b] = sync2_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    // Two-flop synchronizers, debounce levels and the previous level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_raw_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Mode selection with priority stop > run > walk > cycle.
    always_comb begin
        state_d = state_q;
        if (press_s[BTN_STOP]) begin
            state_d = ST_IDLE;
        end else if (press_s[BTN_RUN]) begin
            state_d = select_mode(state_q, ST_RUN);
        end else if (press_s[BTN_WALK]) begin
            state_d = select_mode(state_q, ST_WALK);
        end else if (press_s[BTN_CYCLE]) begin
            state_d = select_mode(state_q, ST_CYCLE);
        end else begin
            state_d = state_q;
        end
    end

    assign state_change_s = (state_d != state_q);

    // Prescaler restarts on every mode change so a partial second is never carried over.
    always_comb begin
        pre_d  = pre_q;
        tick_d = (state_q != ST_IDLE) && (pre_q == PRE_LAST);
        sec_d  = sat_inc16(sec_q, tick_q);
        chg_d  = sat_inc8(chg_q, state_change_s);
        if (state_change_s) begin
            pre_d = '0;
        end else if (state_q == ST_IDLE) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Mode FSM with activity levels registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            walk_q  <= 1'b0;
            cycle_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == ST_RUN);
            walk_q  <= (state_d == ST_WALK);
            cycle_q <= (state_d == ST_CYCLE);
        end
    end

    // Prescaler, tick and saturating session counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            sec_q  <= 16'd0;
            chg_q  <= 8'd0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            sec_q  <= sec_d;
            chg_q  <= chg_d;
        end
    end

    assign Run          = run_q;
    assign Walk         = walk_q;
    assign Cycle        = cycle_q;
    assign active_mode  = state_q;
    assign tick         = tick_q;
    assign session_sec  = sec_q;
    assign mode_changes = chg_q;

endmodule
